// File: rtl/fifo_port_arbiter_if.sv
// Bus bundle between the producers/consumer, the arbiter and the TOP_FIFO pins.
// The arbiter connects through the slave modport; the surrounding logic
// (producers, consumer, FIFO) sees the master view.
interface fifo_port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
);
    localparam int LW = $clog2(DEPTH + 1);

    // Producer 0
    logic             REQ0;
    logic [WIDTH-1:0] DIN0;
    logic             ACK0;
    // Producer 1
    logic             REQ1;
    logic [WIDTH-1:0] DIN1;
    logic             ACK1;
    // Consumer
    logic             RD_REQ;
    logic             RD_VALID;
    logic [WIDTH-1:0] RD_DATA;
    // FIFO pins
    logic [WIDTH-1:0] FIFO_DIN;
    logic             FIFO_WE_N;
    logic             FIFO_OE_N;
    logic [WIDTH-1:0] FIFO_DOUT;
    logic             FIFO_FULL;
    logic             FIFO_EMPTY;
    // Status
    logic [LW-1:0]    LEVEL;
    logic             ERR;

    modport slave (
        input  REQ0, DIN0, REQ1, DIN1, RD_REQ,
        input  FIFO_DOUT, FIFO_FULL, FIFO_EMPTY,
        output ACK0, ACK1, RD_VALID, RD_DATA,
        output FIFO_DIN, FIFO_WE_N, FIFO_OE_N,
        output LEVEL, ERR
    );

    modport master (
        output REQ0, DIN0, REQ1, DIN1, RD_REQ,
        output FIFO_DOUT, FIFO_FULL, FIFO_EMPTY,
        input  ACK0, ACK1, RD_VALID, RD_DATA,
        input  FIFO_DIN, FIFO_WE_N, FIFO_OE_N,
        input  LEVEL, ERR
    );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Two-producer / one-consumer front end for the 8-bit x 1024 TOP_FIFO.
// Round-robin, burst-limited write arbitration; one-per-cycle read issue with
// a fixed-latency return pipeline. Occupancy is tracked locally so that
// full/empty decisions never wait on the FIFO's own (lagging) flags.
module fifo_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    fifo_port_arbiter_if.slave  bus
);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int BW   = $clog2(MAX_BURST + 1);
    // Issue -> RD_VALID takes READ_LAT+2 cycles: one for OE_N, READ_LAT for
    // the FIFO, one for the RD_DATA capture register.
    localparam int NSTG = READ_LAT + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;        // 1 = producer 1 was served most recently
    logic [BW-1:0]    burst_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [WIDTH-1:0] fifo_din_q;
    logic             fifo_we_n_q;
    logic             fifo_oe_n_q;
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  vld_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             err_q;

    logic             full;
    logic             empty;
    logic             ack0;
    logic             ack1;
    logic             accept;
    logic [WIDTH-1:0] wr_data;
    logic             rd_issue;
    logic [BW-1:0]    burst_inc;
    logic             burst_hit;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);

    // Grant is only offered while there is committed room in the FIFO.
    assign ack0      = (state_q == OWN0) && bus.REQ0 && !full;
    assign ack1      = (state_q == OWN1) && bus.REQ1 && !full;
    assign accept    = ack0 || ack1;
    assign wr_data   = ack0 ? bus.DIN0 : bus.DIN1;

    // A read never issues against an empty committed level, regardless of a
    // same-cycle accept, so the FIFO is never popped before the push lands.
    assign rd_issue  = bus.RD_REQ && !empty;

    // The burst limit is reached on the edge of the MAX_BURST-th accept, so the
    // hand-over to the other producer costs no idle cycle.
    assign burst_inc = burst_q + 1'b1;
    assign burst_hit = accept && (burst_inc == BW'(MAX_BURST));

    // Ownership FSM: round-robin between producers with a per-owner burst cap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    burst_q <= '0;
                    if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
                        state_q <= OWN0;
                        last_q  <= 1'b0;
                    end else if (bus.REQ1) begin
                        state_q <= OWN1;
                        last_q  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!bus.REQ0 || burst_hit) begin
                        burst_q <= '0;
                        if (bus.REQ1) begin
                            state_q <= OWN1;
                            last_q  <= 1'b1;
                        end else if (bus.REQ0) begin
                            state_q <= OWN0;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        burst_q <= burst_inc;
                    end
                end
                OWN1: begin
                    if (!bus.REQ1 || burst_hit) begin
                        burst_q <= '0;
                        if (bus.REQ0) begin
                            state_q <= OWN0;
                            last_q  <= 1'b0;
                        end else if (bus.REQ1) begin
                            state_q <= OWN1;
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        burst_q <= burst_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    burst_q <= '0;
                end
            endcase
        end
    end

    // Next committed level: accept and read in the same cycle cancel out.
    always_comb begin
        level_d = level_q;
        if (accept && !rd_issue) begin
            level_d = level_q + 1'b1;
        end else if (!accept && rd_issue) begin
            level_d = level_q - 1'b1;
        end
    end

    // Committed occupancy register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Write port: one-cycle registered strobe; data holds between writes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_din_q  <= '0;
            fifo_we_n_q <= 1'b1;
        end else begin
            fifo_we_n_q <= !accept;
            if (accept) begin
                fifo_din_q <= wr_data;
            end
        end
    end

    // Read valid shift register: stage k is high k+1 cycles after issue.
    always_comb begin
        vld_d = {vld_q[NSTG-2:0], rd_issue};
    end

    // Read port strobe, return pipeline and data capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_oe_n_q <= 1'b1;
            vld_q       <= '0;
            rd_data_q   <= '0;
        end else begin
            fifo_oe_n_q <= !rd_issue;
            vld_q       <= vld_d;
            // FIFO_DOUT is valid in the cycle where stage READ_LAT is set.
            if (vld_q[READ_LAT]) begin
                rd_data_q <= bus.FIFO_DOUT;
            end
        end
    end

    // Sticky error: the FIFO flags contradict a strobe we are driving.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if ((bus.FIFO_FULL && !fifo_we_n_q) ||
                     (bus.FIFO_EMPTY && !fifo_oe_n_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.ACK0      = ack0;
    assign bus.ACK1      = ack1;
    assign bus.FIFO_DIN  = fifo_din_q;
    assign bus.FIFO_WE_N = fifo_we_n_q;
    assign bus.FIFO_OE_N = fifo_oe_n_q;
    assign bus.RD_VALID  = vld_q[NSTG-1];
    assign bus.RD_DATA   = rd_data_q;
    assign bus.LEVEL     = level_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural FIFO model and a
// scoreboard of expected write/read traffic.
module tb_fifo_port_arbiter;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 1024;
    localparam int MAX_BURST = 16;
    localparam int READ_LAT  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_port_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .READ_LAT(READ_LAT)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural TOP_FIFO (READ_LAT = 1) ----------------
    logic [WIDTH-1:0] mem[$];
    logic [WIDTH-1:0] fifo_dout = '0;
    int               fcnt      = 0;
    assign bus.FIFO_DOUT  = fifo_dout;
    assign bus.FIFO_FULL  = (fcnt >= DEPTH);
    assign bus.FIFO_EMPTY = (fcnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.delete();
            fcnt      <= 0;
            fifo_dout <= '0;
        end else begin
            if (!bus.FIFO_OE_N && mem.size() > 0) fifo_dout <= mem.pop_front();
            if (!bus.FIFO_WE_N) mem.push_back(bus.FIFO_DIN);
            fcnt <= mem.size();
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } rd_exp_t;

    rd_exp_t          rd_sb[$];
    logic [WIDTH-1:0] model_q[$];
    int               g_pid[$];
    int               g_cyc[$];
    int               cyc = 0;
    int               exp_level = 0;
    bit               prev_acc = 0;
    bit               prev_rd = 0;
    logic [WIDTH-1:0] prev_data = '0;
    bit               last_acc0 = 0;
    bit               last_acc1 = 0;
    int               ack0_cnt = 0;
    int               ack1_cnt = 0;
    int               we_low_cnt = 0;
    int               rd_cnt = 0;

    always @(negedge clk) begin
        bit               a0;
        bit               a1;
        bit               rd;
        logic [WIDTH-1:0] wd;
        rd_exp_t          e;
        cyc++;
        if (!rst_n) begin
            rd_sb.delete(); model_q.delete(); g_pid.delete(); g_cyc.delete();
            exp_level = 0; prev_acc = 0; prev_rd = 0; prev_data = '0;
            last_acc0 = 0; last_acc1 = 0;
            ack0_cnt = 0; ack1_cnt = 0; we_low_cnt = 0; rd_cnt = 0;
        end else begin
            chk("level", bus.LEVEL, exp_level);
            chk("err", bus.ERR, 0);
            chk("we_n", bus.FIFO_WE_N, !prev_acc);
            if (prev_acc) chk("fifo_din", bus.FIFO_DIN, prev_data);
            if (!bus.FIFO_WE_N) we_low_cnt++;
            chk("oe_n", bus.FIFO_OE_N, !prev_rd);
            if (rd_sb.size() > 0 && rd_sb[0].due == cyc) begin
                e = rd_sb.pop_front();
                chk("rd_valid", bus.RD_VALID, 1);
                chk("rd_data", bus.RD_DATA, e.data);
                rd_cnt++;
            end else begin
                chk("rd_valid_idle", bus.RD_VALID, 0);
            end
            a0 = bus.REQ0 && bus.ACK0;
            a1 = bus.REQ1 && bus.ACK1;
            if (exp_level == DEPTH) chk("ack_full", bus.ACK0 | bus.ACK1, 0);
            chk("ack_excl", bus.ACK0 & bus.ACK1, 0);
            rd = bus.RD_REQ && (exp_level != 0);
            wd = a0 ? bus.DIN0 : bus.DIN1;
            if (rd) begin
                e.data = model_q.pop_front();
                e.due  = cyc + READ_LAT + 2;
                rd_sb.push_back(e);
            end
            if (a0 || a1) begin
                model_q.push_back(wd);
                g_pid.push_back(a1 ? 1 : 0);
                g_cyc.push_back(cyc);
                if (a0) ack0_cnt++;
                if (a1) ack1_cnt++;
            end
            exp_level = exp_level + ((a0 || a1) ? 1 : 0) - (rd ? 1 : 0);
            prev_acc  = a0 || a1;
            prev_rd   = rd;
            prev_data = wd;
            last_acc0 = a0;
            last_acc1 = a1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk_reset_outputs();
        chk("rst_ack0", bus.ACK0, 0);
        chk("rst_ack1", bus.ACK1, 0);
        chk("rst_we_n", bus.FIFO_WE_N, 1);
        chk("rst_oe_n", bus.FIFO_OE_N, 1);
        chk("rst_din", bus.FIFO_DIN, 0);
        chk("rst_rd_valid", bus.RD_VALID, 0);
        chk("rst_rd_data", bus.RD_DATA, 0);
        chk("rst_level", bus.LEVEL, 0);
        chk("rst_err", bus.ERR, 0);
    endtask

    task automatic do_reset();
        bus.REQ0 = 0; bus.REQ1 = 0; bus.RD_REQ = 0;
        bus.DIN0 = 8'h00; bus.DIN1 = 8'h80;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Run up to ncyc cycles; producers advance their data after each accept.
    // With stop_at > 0, both requests drop once that many words were accepted.
    task automatic run(input int ncyc, input int stop_at);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (last_acc0) bus.DIN0 = bus.DIN0 + 1'b1;
            if (last_acc1) bus.DIN1 = bus.DIN1 + 1'b1;
            if (stop_at > 0 && (ack0_cnt + ack1_cnt) >= stop_at) begin
                bus.REQ0 = 0;
                bus.REQ1 = 0;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gaps;
        bus.REQ0 = 0; bus.REQ1 = 0; bus.RD_REQ = 0;
        bus.DIN0 = 8'h00; bus.DIN1 = 8'h80;

        // Power-on reset values
        #1 rst_n = 0;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Single producer: 20 contiguous words across a burst boundary
        do_reset();
        bus.REQ0 = 1;
        run(60, 20);
        chk("single_acks", ack0_cnt, 20);
        chk("single_span", (g_cyc.size() >= 20) ? (g_cyc[19] - g_cyc[0]) : -1, 19);
        run(3, 0);
        chk("single_level", bus.LEVEL, 20);
        chk("single_we_low", we_low_cnt, 20);
        chk("single_err", bus.ERR, 0);

        // Contention: 16/16 alternation with no idle cycle at the switch
        do_reset();
        bus.REQ0 = 1; bus.REQ1 = 1;
        run(120, 64);
        chk("cont_acks", ack0_cnt + ack1_cnt, 64);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("cont_pid[%0d]", k), (k < g_pid.size()) ? g_pid[k] : -1, (k / MAX_BURST) % 2);
        end
        gaps = 0;
        for (int k = 1; k < g_cyc.size(); k++) if (g_cyc[k] != g_cyc[k-1] + 1) gaps++;
        chk("cont_gaps", gaps, 0);
        run(3, 0);

        // Fill to full with 1030+ request cycles
        do_reset();
        bus.REQ0 = 1;
        run(1040, 0);
        chk("fill_acks", ack0_cnt, DEPTH);
        @(negedge clk);
        chk("fill_level", bus.LEVEL, DEPTH);
        chk("fill_ack_low", bus.ACK0, 0);

        // Same-cycle read and write request at LEVEL == DEPTH
        @(posedge clk); #1 bus.RD_REQ = 1;
        @(negedge clk);
        chk("full_rw_ack", bus.ACK0, 0);
        @(posedge clk); #1 bus.RD_REQ = 0; bus.REQ0 = 0;
        @(negedge clk);
        chk("full_rw_level", bus.LEVEL, DEPTH - 1);

        // Drain in write order
        @(posedge clk); #1 bus.RD_REQ = 1;
        run(1040, 0);
        bus.RD_REQ = 0;
        run(6, 0);
        chk("drain_rd_cnt", rd_cnt, DEPTH);
        chk("drain_level", bus.LEVEL, 0);
        chk("drain_err", bus.ERR, 0);

        // Same-cycle read and write at LEVEL == 5
        do_reset();
        bus.REQ0 = 1;
        run(30, 5);
        run(3, 0);
        chk("lvl5_pre", bus.LEVEL, 5);
        bus.REQ0 = 1;
        run(1, 0);
        bus.RD_REQ = 1;
        @(negedge clk);
        chk("lvl5_rw_ack", bus.ACK0, 1);
        @(posedge clk); #1 bus.REQ0 = 0; bus.RD_REQ = 0;
        @(negedge clk);
        chk("lvl5_rw_level", bus.LEVEL, 5);

        // Asynchronous reset mid-burst with reads in flight
        @(posedge clk); #1 bus.REQ0 = 1; bus.RD_REQ = 1;
        run(6, 0);
        #2 rst_n = 0;
        #1 chk_reset_outputs();
        bus.REQ0 = 0; bus.RD_REQ = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        run(8, 0);
        chk("post_rst_level", bus.LEVEL, 0);
        chk("post_rst_rd_cnt", rd_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Shares the write port of the 8-bit x 1024 TOP_FIFO between two producers with round-robin, burst-limited arbitration.
- Sequences the FIFO read port for one consumer.
- Tracks FIFO occupancy internally so that full/empty decisions never depend on the FIFO's flags, which lag by a cycle.
- Sits between the producer/consumer logic and the FIFO's DIN/WE_N/OE_N/DOUT/FULL/EMPTY pins.

Parameters:
WIDTH, 8, data width; matches the FIFO.
DEPTH, 1024, FIFO capacity in words.
MAX_BURST, 16, maximum words one producer may write per ownership period; must be at least 1.
READ_LAT, 1, cycles between the FIFO read edge and FIFO_DOUT being valid.

Ports:
CLK  in  1  clock; all logic is on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
REQ0  in  1  producer 0 has a word on DIN0.
DIN0  in  WIDTH  producer 0 data.
ACK0  out  1  producer 0 word accepted this cycle.
REQ1  in  1  producer 1 has a word on DIN1.
DIN1  in  WIDTH  producer 1 data.
ACK1  out  1  producer 1 word accepted this cycle.
RD_REQ  in  1  consumer requests a word.
RD_VALID  out  1  one-cycle pulse; RD_DATA is valid.
RD_DATA  out  WIDTH  read data.
FIFO_DIN  out  WIDTH  to FIFO DIN.
FIFO_WE_N  out  1  to FIFO WE_N; active low.
FIFO_OE_N  out  1  to FIFO OE_N; active low.
FIFO_DOUT  in  WIDTH  from FIFO DOUT.
FIFO_FULL  in  1  from FIFO FULL.
FIFO_EMPTY  in  1  from FIFO EMPTY.
LEVEL  out  $clog2(DEPTH+1)  committed occupancy.
ERR  out  1  sticky protocol-error flag.

Behaviour:
- Clocking and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: ACK0=ACK1=0, FIFO_WE_N=1, FIFO_OE_N=1, FIFO_DIN=0, RD_VALID=0, RD_DATA=0, LEVEL=0, ERR=0.
- Internal reset state: state=IDLE, last-served=1 (so producer 0 wins the first tie), burst count=0, read pipeline cleared.
- The FIFO shares RST_N. Reset mid-operation discards in-flight reads and any pending write.
- State machine, states IDLE, OWN0, OWN1:
  - IDLE: only REQ0 -> OWN0; only REQ1 -> OWN1; both -> the producer not last served; neither -> IDLE.
  - OWNi, ownership ends when REQi drops or burst count reaches MAX_BURST.
  - On end: other REQ high -> OWN of the other producer, burst=0. Else REQi still high -> stay in OWNi, burst=0. Else -> IDLE.
  - Last-served is updated on every entry to OWNi.
- Write acceptance:
  - ACKi = (state==OWNi) & REQi & (LEVEL < DEPTH). This is combinational from REQi and registered state.
  - A word transfers in any cycle where REQi and ACKi are both high.
  - On the following edge: FIFO_DIN <= DINi, FIFO_WE_N <= 0, burst++.
  - Otherwise FIFO_WE_N <= 1; FIFO_DIN holds its value.
  - When LEVEL==DEPTH, ownership is kept, ACK stays low, burst is not counted, and no grant switch occurs.
- Read issue:
  - A read issues in any cycle with RD_REQ & (LEVEL != 0). The next edge drives FIFO_OE_N <= 0 for exactly one cycle.
  - RD_REQ held high gives back-to-back reads, one per cycle.
  - RD_DATA is captured from FIFO_DOUT and RD_VALID pulses exactly READ_LAT+2 cycles after the issue cycle; this is a valid shift register.
  - Reads are returned in issue order.
- LEVEL:
  - +1 on accept, -1 on read issue, unchanged when both occur.
  - An accept at LEVEL==DEPTH is never allowed, even with a same-cycle read.
  - A read at LEVEL==0 is never issued, even with a same-cycle accept.
  - LEVEL never wraps.
- ERR: set when FIFO_FULL=1 while FIFO_WE_N=0, or FIFO_EMPTY=1 while FIFO_OE_N=0. Cleared only by reset.
- Write path latency: 1 cycle from accept to FIFO_WE_N low.

Test Plan:
- Reset check: assert RST_N low mid-burst. Required: all outputs go to their reset values asynchronously, LEVEL=0, and a pending RD_VALID never appears.
- Single producer: REQ0 held high with DIN0=0..19 and MAX_BURST=16. Required: 20 contiguous ACK0 pulses; FIFO_WE_N low 20 cycles, each one cycle after its ACK; LEVEL=20; ERR=0.
- Contention: REQ0 and REQ1 both held high. Required: grant sequence is 16 words from producer 0, then 16 from producer 1, alternating, with no idle cycle at the switch.
- Fill to full: write 1030 words. Required: exactly 1024 ACKs; LEVEL=1024; ACK low while full; ERR=0.
- Drain: then hold RD_REQ high. Required: 1024 RD_VALID pulses with data in write order; FIFO_OE_N stays high at LEVEL=0; FIFO_EMPTY never sampled high during a read, so ERR=0.
- Same-cycle read and write at LEVEL=5: Required: LEVEL stays 5. At LEVEL=1024 the same case gives LEVEL=1023 and no ACK that cycle.
